// File: rtl/blinds_motor_controller_pkg.sv
// blinds_motor_controller_pkg: shared state encoding, default sun thresholds and hour limit
package blinds_motor_controller_pkg;
  typedef enum logic [1:0] {CLOSED = 2'd0, OPENING = 2'd1, OPEN = 2'd2, CLOSING = 2'd3} blind_state_e;
  localparam int DEF_SUN_HI = 136;
  localparam int DEF_SUN_LO = 120;
  localparam int HOUR_MAX = 23;
endpackage

// File: rtl/blinds_channel_fsm.sv
// blinds_channel_fsm: one blind channel with sun hysteresis, registered target and position FSM
// Manual override ports exist only when BLINDS_MANUAL_OVERRIDE_EN is defined.
module blinds_channel_fsm
  import blinds_motor_controller_pkg::*;
#(
  parameter int TRAVEL_TICKS = 100,
  parameter int SUN_HI = DEF_SUN_HI,
  parameter int SUN_LO = DEF_SUN_LO
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid,
  input  logic       time_ok,
  input  logic [7:0] level,
  input  logic       tick,
`ifdef BLINDS_MANUAL_OVERRIDE_EN
  input  logic       manual_en,
  input  logic       manual_dir,
`endif
  output logic       motor_up,
  output logic       motor_down,
  output logic       is_open,
  output logic       busy,
  output logic [7:0] position
);
  localparam logic [7:0] TOP = 8'(TRAVEL_TICKS);
  localparam logic [7:0] HI = 8'(SUN_HI);
  localparam logic [7:0] LO = 8'(SUN_LO);
  blind_state_e state, state_n;
  logic sun_flag, sun_n, target, target_n, moving;
  logic [7:0] pos_n;
  assign moving = (state == OPENING) || (state == CLOSING);
  always_comb begin
    sun_n = !valid ? sun_flag : level > HI ? 1'b1 : level < LO ? 1'b0 : sun_flag;
`ifdef BLINDS_MANUAL_OVERRIDE_EN
    target_n = manual_en ? manual_dir : valid ? (time_ok | sun_n) : target;
`else
    target_n = valid ? (time_ok | sun_n) : target;
`endif
    // direction follows the live target, so a tick on a reversal edge moves the new way
    pos_n = !(moving && tick) ? position
          : target ? (position == TOP ? position : position + 8'd1)
          : (position == 8'd0 ? position : position - 8'd1);
    state_n = moving ? (target ? ((tick && pos_n == TOP) ? OPEN : OPENING)
                               : ((tick && pos_n == 8'd0) ? CLOSED : CLOSING))
            : state == CLOSED ? (target ? OPENING : CLOSED)
            : (target ? OPEN : CLOSING);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= CLOSED;
      position <= 8'd0;
      sun_flag <= 1'b0;
      target   <= 1'b0;
    end else begin
      state    <= state_n;
      position <= pos_n;
      sun_flag <= sun_n;
      target   <= target_n;
    end
  end
  assign motor_up   = state == OPENING;
  assign motor_down = state == CLOSING;
  assign is_open    = state == OPEN;
  assign busy       = motor_up | motor_down;
endmodule

// File: rtl/blinds_motor_controller.sv
// blinds_motor_controller: N_CH independent blind channels sharing time of day and motor tick
// Define BLINDS_MANUAL_OVERRIDE_EN to add per-channel manual override ports.
module blinds_motor_controller
  import blinds_motor_controller_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TRAVEL_TICKS = 100,
  parameter int OPEN_HOUR = 8,
  parameter int CLOSE_HOUR = 17,
  parameter int SUN_HI = DEF_SUN_HI,
  parameter int SUN_LO = DEF_SUN_LO
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              blinds_controller_valid_i,
  input  logic [11:0]       time_i,
  input  logic [N_CH*8-1:0] sunlight_level_i,
  input  logic              tick_i,
`ifdef BLINDS_MANUAL_OVERRIDE_EN
  input  logic [N_CH-1:0]   manual_en_i,
  input  logic [N_CH-1:0]   manual_dir_i,
`endif
  output logic [N_CH-1:0]   motor_up_o,
  output logic [N_CH-1:0]   motor_down_o,
  output logic [N_CH*8-1:0] position_o,
  output logic [N_CH-1:0]   blinds_status_o,
  output logic [N_CH-1:0]   busy_o
);
  logic [5:0] hour;
  logic time_ok;
  assign hour = time_i[11:6];
  assign time_ok = int'(hour) > OPEN_HOUR && int'(hour) < CLOSE_HOUR && int'(hour) <= HOUR_MAX;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    blinds_channel_fsm #(
      .TRAVEL_TICKS(TRAVEL_TICKS),
      .SUN_HI(SUN_HI),
      .SUN_LO(SUN_LO)
    ) u_ch (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .valid(blinds_controller_valid_i),
      .time_ok(time_ok),
      .level(sunlight_level_i[8*c +: 8]),
      .tick(tick_i),
`ifdef BLINDS_MANUAL_OVERRIDE_EN
      .manual_en(manual_en_i[c]),
      .manual_dir(manual_dir_i[c]),
`endif
      .motor_up(motor_up_o[c]),
      .motor_down(motor_down_o[c]),
      .is_open(blinds_status_o[c]),
      .busy(busy_o[c]),
      .position(position_o[8*c +: 8])
    );
  end
endmodule
